udp_port_filter_in: RTL and testbench
=====================================

Name: udp_port_filter_in

Overview:
Parametrised store-and-forward ingress filter for the server operand path. Classifies each AXI-Stream packet by IP protocol (beat 0) and UDP destination port (beat 1) against a runtime table of NUM_PORTS entries. Only matching, complete packets are committed to an internal buffer. Non-matching, runt and overflowing packets are rolled back and counted, never partially exposed. Downstream reads through a standard AXIS master with tready.

Parameters:
C_S_AXIS_DATA_WIDTH, 256, tdata width (multiple of 64, >=192)
C_S_AXIS_TUSER_WIDTH, 128, tuser width
DEPTH_BITS, 10, buffer depth = 2**DEPTH_BITS beats
NUM_PORTS, 4, destination-port match entries (1..16)

Ports:
axis_aclk  in  1  clock
axis_reset  in  1  synchronous, active-high reset
s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  input data
s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  input byte enables
s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  input sideband
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  constant 1 after reset (block drops, never backpressures)
s_axis_tlast  in  1  input end of packet
m_axis_tdata/tkeep/tuser/tlast  out  as s_*  committed beat at buffer head
m_axis_tvalid  out  1  committed beat available
m_axis_tready  in  1  downstream accept
i_cfg_proto  in  8  protocol to match (UDP = 8'h11)
i_cfg_port  in  NUM_PORTS*16  port table, entry k at [16k+15:16k]
i_cfg_port_en  in  NUM_PORTS  per-entry enable
i_cfg_bypass  in  1  1 = commit every complete packet, no filtering
o_accept_cnt  out  32  committed packets, wraps
o_drop_cnt  out  32  packets rejected by filter or runt, wraps
o_ovf_cnt  out  32  packets dropped by buffer overflow, wraps

Behaviour:
- Reset: pointers, state and counters go to 0; state = IDLE; m_axis_tvalid = 0; s_axis_tready = 0 during reset and 1 afterwards. The partial packet in the buffer is lost. Upstream is reset together with this block.
- Handshake: a beat is taken on s_tvalid & s_tready. Output transfers on m_tvalid & m_tready. m_* hold stable while tvalid & !tready.
- Pointers are DEPTH_BITS+1 wide: wr_ptr (speculative), cm_ptr (committed), rd_ptr. Full when wr_ptr-rd_ptr == 2**DEPTH_BITS. m_tvalid = (rd_ptr != cm_ptr). Output is first-word-fallthrough.
- Config is sampled on beat 0 and held for that packet.
- Match = (tdata[191:184] of beat 0 == proto) & OR over k of (en[k] & tdata[47:32] of beat 1 == port[k]). If bypass is 1, match = 1.
- States:
  - IDLE (beat 0): write the beat. If tlast is set: bypass commits, otherwise drop (runt). If protocol matches or bypass, go to HDR2. Else go to DISCARD and roll back wr_ptr to cm_ptr.
  - HDR2 (beat 1): write the beat. If the port matches, go to STORE (or commit if tlast). Else roll back; go to DISCARD, or IDLE with drop counted if tlast.
  - STORE: write each beat. On tlast, commit and go to IDLE.
  - DISCARD: no writes. On tlast, increment drop count and go to IDLE.
- Overflow: a beat arriving while full in IDLE/HDR2/STORE sets ovf. Writes stop, and wr_ptr rolls back to cm_ptr on the following cycle. The packet is then handled as DISCARD, but at tlast o_ovf_cnt increments instead of o_drop_cnt. A packet larger than the buffer is always dropped, so there is no deadlock.
- Commit: the tlast beat is written in cycle T; cm_ptr <= wr_ptr+1 at the T edge; m_tvalid is high from T+1. Latency is tlast + 1 cycle. o_accept_cnt increments in the same cycle.
- Simultaneous read and write/commit in one cycle is legal; full is evaluated with the pre-read rd_ptr (conservative).
- Back-to-back packets with no idle cycle are supported at full rate.

Decomposition:
- Package udp_filter_pkg: field offsets PROTO_HI=191/PROTO_LO=184, DPORT_HI=47/DPORT_LO=32, IPPROT_UDP=8'h11, state encodings IDLE/HDR2/STORE/DISCARD.
- Sub-module commit_fifo: dual-port RAM plus wr/cm/rd pointers, with inputs wr_en, commit, rollback and outputs full and committed-empty. The filter FSM and counters stay in the top level.

Test Plan:
- Bypass=0, proto 8'h11, port table {5001 en}, 4-beat packet with dport 5001 -> 4 beats out, identical data/tkeep/tuser, tlast on beat 4, m_tvalid one cycle after the input tlast, accept=1.
- Same packet with dport 5002, then a matching packet back-to-back -> only the second appears; drop=1, accept=1, no residue beats.
- Protocol 8'h06, 3 beats -> nothing out, drop=1. Then i_cfg_bypass=1 with the same packet -> 3 beats out.
- 1-beat runt (tlast on beat 0) with bypass=0 -> drop=1, no output.
- DEPTH_BITS=4, m_tready=0, 10-beat match then 10-beat match -> first is committed, second gets ovf=1; release tready -> exactly 10 beats out. Also a 20-beat packet on an empty buffer -> ovf increments, buffer empty.
- Assert axis_reset mid-STORE with 2 beats committed and unread -> m_tvalid=0 and counters 0 next cycle; a fresh matching packet afterwards passes normally.

Source files
------------

// File: rtl/udp_filter_pkg.sv
// Shared constants and state encoding for the UDP ingress port filter.
// Header field positions are given as bit offsets within beat 0 and beat 1.
package udp_filter_pkg;

  localparam int PROTO_HI = 191;
  localparam int PROTO_LO = 184;
  localparam int DPORT_HI = 47;
  localparam int DPORT_LO = 32;

  localparam logic [7:0] IPPROT_UDP = 8'h11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR2    = 2'd1,
    ST_STORE   = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

endpackage

// File: rtl/udp_port_filter_in_commit_fifo.sv
// Packet buffer with a speculative write pointer, a committed pointer and a read pointer.
// Only beats below the committed pointer are visible to the reader (first-word fall-through).
module commit_fifo #(
  parameter int WIDTH      = 417,
  parameter int DEPTH_BITS = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_commit,
  input  logic             i_rollback,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_LVL = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_BITS:0] r_wr_ptr;
  logic [DEPTH_BITS:0] r_cm_ptr;
  logic [DEPTH_BITS:0] r_rd_ptr;
  logic [DEPTH_BITS:0] w_base;
  logic [DEPTH_BITS:0] w_wr_next;
  logic                w_rd_fire;

  // A rollback in the same cycle as a write places the beat at the committed
  // pointer, so a new packet can start while a dropped one is being unwound.
  assign w_base    = i_rollback ? r_cm_ptr : r_wr_ptr;
  assign w_wr_next = w_base + (DEPTH_BITS + 1)'(i_wr_en);
  assign o_full    = (w_base - r_rd_ptr) == FULL_LVL;
  assign o_empty   = (r_rd_ptr == r_cm_ptr);
  assign w_rd_fire = i_rd_en & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[DEPTH_BITS-1:0]];

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and a resettable array cannot map to RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[w_base[DEPTH_BITS-1:0]] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_cm_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      if (i_commit) r_cm_ptr <= w_wr_next;
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/udp_port_filter_in.sv
// Store-and-forward ingress filter: classifies packets by IP protocol and UDP
// destination port, commits matching packets and rolls back everything else.
module udp_port_filter_in
  import udp_filter_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_BITS           = 10,
  parameter int NUM_PORTS            = 4
) (
  input  logic                              axis_aclk,
  input  logic                              axis_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic [7:0]                        i_cfg_proto,
  input  logic [NUM_PORTS*16-1:0]           i_cfg_port,
  input  logic [NUM_PORTS-1:0]              i_cfg_port_en,
  input  logic                              i_cfg_bypass,
  output logic [31:0]                       o_accept_cnt,
  output logic [31:0]                       o_drop_cnt,
  output logic [31:0]                       o_ovf_cnt
);

  localparam int DW     = C_S_AXIS_DATA_WIDTH;
  localparam int KW     = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int BEAT_W = DW + KW + UW + 1;

  state_t                 r_state;
  logic                   r_ovf;
  logic                   r_ovf_rb;
  logic                   r_tready;
  logic [NUM_PORTS*16-1:0] r_cfg_port;
  logic [NUM_PORTS-1:0]   r_cfg_port_en;
  logic                   r_cfg_bypass;
  logic [31:0]            r_accept_cnt;
  logic [31:0]            r_drop_cnt;
  logic [31:0]            r_ovf_cnt;

  logic              w_beat;
  logic              w_full;
  logic              w_empty;
  logic              w_proto_hit;
  logic              w_port_hit;
  logic              w_hdr2_match;
  logic              w_ovf_beat;
  logic              w_wr_en;
  logic              w_commit;
  logic              w_rollback;
  logic [BEAT_W-1:0] w_beat_in;
  logic [BEAT_W-1:0] w_beat_out;

  assign w_beat       = s_axis_tvalid & r_tready;
  assign w_proto_hit  = (s_axis_tdata[PROTO_HI:PROTO_LO] == i_cfg_proto);
  assign w_hdr2_match = r_cfg_bypass | w_port_hit;
  assign w_ovf_beat   = w_beat & w_full & (r_state != ST_DISCARD);
  assign w_beat_in    = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statement can leave it holding a value (a latch).
  always_comb begin
    w_port_hit = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (r_cfg_port_en[k] && (s_axis_tdata[DPORT_HI:DPORT_LO] == r_cfg_port[16*k +: 16]))
        w_port_hit = 1'b1;
    end
  end

  // Buffer strobes: beats of a packet that is already known to be rejected are
  // never written, so rollback only has to unwind beats of a dying candidate.
  always_comb begin
    w_wr_en    = 1'b0;
    w_commit   = 1'b0;
    w_rollback = r_ovf_rb;
    if (w_beat && !w_full) begin
      case (r_state)
        ST_IDLE: begin
          if (i_cfg_bypass) begin
            w_wr_en  = 1'b1;
            w_commit = s_axis_tlast;
          end else if (w_proto_hit && !s_axis_tlast) begin
            w_wr_en = 1'b1;
          end
        end
        ST_HDR2: begin
          if (w_hdr2_match) begin
            w_wr_en  = 1'b1;
            w_commit = s_axis_tlast;
          end else begin
            w_rollback = 1'b1;
          end
        end
        ST_STORE: begin
          w_wr_en  = 1'b1;
          w_commit = s_axis_tlast;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // branch below sees the pre-edge values of r_state and the counters.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      r_state       <= ST_IDLE;
      r_ovf         <= 1'b0;
      r_ovf_rb      <= 1'b0;
      r_tready      <= 1'b0;
      r_cfg_port    <= '0;
      r_cfg_port_en <= '0;
      r_cfg_bypass  <= 1'b0;
      r_accept_cnt  <= '0;
      r_drop_cnt    <= '0;
      r_ovf_cnt     <= '0;
    end else begin
      r_tready <= 1'b1;
      r_ovf_rb <= 1'b0;
      if (w_beat && r_state == ST_IDLE) begin
        r_cfg_port    <= i_cfg_port;
        r_cfg_port_en <= i_cfg_port_en;
        r_cfg_bypass  <= i_cfg_bypass;
      end
      if (w_ovf_beat) begin
        // Speculative beats are unwound one cycle later via r_ovf_rb.
        r_ovf_rb <= 1'b1;
        if (s_axis_tlast) begin
          r_ovf_cnt <= r_ovf_cnt + 32'd1;
          r_state   <= ST_IDLE;
        end else begin
          r_ovf   <= 1'b1;
          r_state <= ST_DISCARD;
        end
      end else if (w_beat) begin
        case (r_state)
          ST_IDLE: begin
            if (s_axis_tlast) begin
              if (i_cfg_bypass) r_accept_cnt <= r_accept_cnt + 32'd1;
              else              r_drop_cnt   <= r_drop_cnt + 32'd1;
            end else if (i_cfg_bypass || w_proto_hit) begin
              r_state <= ST_HDR2;
            end else begin
              r_ovf   <= 1'b0;
              r_state <= ST_DISCARD;
            end
          end
          ST_HDR2: begin
            if (w_hdr2_match) begin
              if (s_axis_tlast) begin
                r_accept_cnt <= r_accept_cnt + 32'd1;
                r_state      <= ST_IDLE;
              end else begin
                r_state <= ST_STORE;
              end
            end else if (s_axis_tlast) begin
              r_drop_cnt <= r_drop_cnt + 32'd1;
              r_state    <= ST_IDLE;
            end else begin
              r_ovf   <= 1'b0;
              r_state <= ST_DISCARD;
            end
          end
          ST_STORE: begin
            if (s_axis_tlast) begin
              r_accept_cnt <= r_accept_cnt + 32'd1;
              r_state      <= ST_IDLE;
            end
          end
          ST_DISCARD: begin
            if (s_axis_tlast) begin
              if (r_ovf) r_ovf_cnt  <= r_ovf_cnt + 32'd1;
              else       r_drop_cnt <= r_drop_cnt + 32'd1;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  commit_fifo #(
    .WIDTH      (BEAT_W),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .i_clk      (axis_aclk),
    .i_rst      (axis_reset),
    .i_wr_en    (w_wr_en),
    .i_wr_data  (w_beat_in),
    .i_commit   (w_commit),
    .i_rollback (w_rollback),
    .i_rd_en    (m_axis_tready),
    .o_rd_data  (w_beat_out),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign s_axis_tready = r_tready;
  assign m_axis_tvalid = ~w_empty;
  assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = w_beat_out;
  assign o_accept_cnt  = r_accept_cnt;
  assign o_drop_cnt    = r_drop_cnt;
  assign o_ovf_cnt     = r_ovf_cnt;

endmodule

// File: tb/tb_udp_port_filter_in.sv
// Bench for udp_port_filter_in: packet-level reference model with a beat queue
// per committed packet and an occupancy-based overflow rule.
module tb_udp_port_filter_in;
  import udp_filter_pkg::*;

  localparam int DW = 256, KW = 32, UW = 128, DB = 4, NP = 4;
  localparam int DEPTH = 1 << DB;

  logic             axis_aclk, axis_reset;
  logic [DW-1:0]    s_axis_tdata;
  logic [KW-1:0]    s_axis_tkeep;
  logic [UW-1:0]    s_axis_tuser;
  logic             s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0]    m_axis_tdata;
  logic [KW-1:0]    m_axis_tkeep;
  logic [UW-1:0]    m_axis_tuser;
  logic             m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0]       i_cfg_proto;
  logic [NP*16-1:0] i_cfg_port;
  logic [NP-1:0]    i_cfg_port_en;
  logic             i_cfg_bypass;
  logic [31:0]      o_accept_cnt, o_drop_cnt, o_ovf_cnt;

  udp_port_filter_in #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .DEPTH_BITS(DB), .NUM_PORTS(NP)
  ) dut (
    .axis_aclk(axis_aclk), .axis_reset(axis_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .i_cfg_proto(i_cfg_proto), .i_cfg_port(i_cfg_port), .i_cfg_port_en(i_cfg_port_en),
    .i_cfg_bypass(i_cfg_bypass),
    .o_accept_cnt(o_accept_cnt), .o_drop_cnt(o_drop_cnt), .o_ovf_cnt(o_ovf_cnt)
  );

  typedef struct packed {
    logic          last;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  typedef enum {PK_KEEP, PK_DROP, PK_OVF} pk_status_e;

  int checks = 0;
  int failures = 0;

  // Reference model state: committed-unread beats, the candidate packet's beats,
  // the packet verdict so far and the configuration captured on its first beat.
  beat_t       exp_q[$];
  beat_t       spec_q[$];
  beat_t       pkt_q[$];
  int          m_idx = 0;
  pk_status_e  m_status = PK_KEEP;
  logic [NP*16-1:0] m_port;
  logic [NP-1:0]    m_en;
  logic             m_bypass;
  int unsigned m_acc = 0, m_drop = 0, m_ovf = 0;
  int          n_out = 0;
  int          rdy_mode = 1;

  initial axis_aclk = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic port_hit(input logic [15:0] dp);
    for (int k = 0; k < NP; k++)
      if (m_en[k] && m_port[16*k +: 16] == dp) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_beat(input beat_t b);
    logic keep_it;
    if (m_idx == 0) begin
      m_port = i_cfg_port; m_en = i_cfg_port_en; m_bypass = i_cfg_bypass;
      m_status = PK_KEEP;
      spec_q.delete();
    end
    if (m_status == PK_KEEP) begin
      if (exp_q.size() + spec_q.size() >= DEPTH) begin
        m_status = PK_OVF;
        spec_q.delete();
      end else begin
        if (m_idx == 0)      keep_it = m_bypass || (b.data[PROTO_HI:PROTO_LO] == i_cfg_proto && !b.last);
        else if (m_idx == 1) keep_it = m_bypass || port_hit(b.data[DPORT_HI:DPORT_LO]);
        else                 keep_it = 1'b1;
        if (keep_it) spec_q.push_back(b);
        else begin m_status = PK_DROP; spec_q.delete(); end
      end
    end
    if (b.last) begin
      case (m_status)
        PK_KEEP: begin foreach (spec_q[i]) exp_q.push_back(spec_q[i]); m_acc++; end
        PK_DROP: m_drop++;
        default: m_ovf++;
      endcase
      spec_q.delete();
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Called just after a falling edge: checks the outputs produced by the last
  // rising edge, drives inputs for the next one and advances the model.
  task automatic step(input beat_t b, input logic v);
    logic  rdy, rd;
    beat_t got;
    checks++;
    if (m_axis_tvalid !== (exp_q.size() != 0)) begin
      failures++;
      $display("FAIL m_tvalid: got %b expected %b", m_axis_tvalid, exp_q.size() != 0);
    end
    rdy = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    rd  = rdy && (exp_q.size() != 0);
    if (rd && m_axis_tvalid === 1'b1) begin
      got = {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};
      n_out++;
      checks++;
      if (got !== exp_q[0]) begin
        failures++;
        $display("FAIL out_beat: got %h expected %h", got, exp_q[0]);
      end
    end
    if (v) begin
      checks++;
      if (s_axis_tready !== 1'b1) begin
        failures++;
        $display("FAIL s_tready: got %b expected 1", s_axis_tready);
      end
    end
    s_axis_tvalid = v;
    s_axis_tdata  = b.data;
    s_axis_tkeep  = b.keep;
    s_axis_tuser  = b.user;
    s_axis_tlast  = b.last;
    m_axis_tready = rdy;
    if (v) model_beat(b);
    if (rd) void'(exp_q.pop_front());
    @(negedge axis_aclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0);
  endtask

  task automatic make_pkt(input logic [7:0] proto, input logic [15:0] dport, input int len);
    beat_t b;
    pkt_q.delete();
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < DW / 32; w++) b.data[32*w +: 32] = $urandom();
      for (int w = 0; w < UW / 32; w++) b.user[32*w +: 32] = $urandom();
      b.keep = $urandom();
      b.last = (i == len - 1);
      if (i == 0) b.data[PROTO_HI:PROTO_LO] = proto;
      if (i == 1) b.data[DPORT_HI:DPORT_LO] = dport;
      pkt_q.push_back(b);
    end
  endtask

  task automatic send_pkt(input int gap_pct, input bit scramble, input int max_beats);
    for (int i = 0; i < pkt_q.size() && i < max_beats; i++) begin
      if (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) idle(1);
      if (scramble && i > 0 && $urandom_range(0, 2) == 0) begin
        for (int k = 0; k < NP; k++) i_cfg_port[16*k +: 16] = 16'($urandom_range(5000, 5007));
        i_cfg_port_en = 4'($urandom());
        i_cfg_bypass  = 1'($urandom_range(0, 1));
      end
      step(pkt_q[i], 1'b1);
    end
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset(input int n);
    axis_reset    = 1'b1;
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge axis_aclk);
    exp_q.delete(); spec_q.delete();
    m_idx = 0; m_acc = 0; m_drop = 0; m_ovf = 0;
    checks++;
    if ({s_axis_tready, m_axis_tvalid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready_valid: got %b expected 00", {s_axis_tready, m_axis_tvalid});
    end
    checks++;
    if ({o_accept_cnt, o_drop_cnt, o_ovf_cnt} !== 96'd0) begin
      failures++;
      $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", o_accept_cnt, o_drop_cnt, o_ovf_cnt);
    end
    axis_reset = 1'b0;
    @(negedge axis_aclk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_tready: got %b expected 1", s_axis_tready);
    end
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (o_accept_cnt !== m_acc || o_drop_cnt !== m_drop || o_ovf_cnt !== m_ovf) begin
      failures++;
      $display("FAIL %s_counters: got acc=%0d drop=%0d ovf=%0d expected acc=%0d drop=%0d ovf=%0d",
               tag, o_accept_cnt, o_drop_cnt, o_ovf_cnt, m_acc, m_drop, m_ovf);
    end
  endtask

  task automatic check_out(input string tag, input int n0, input int want);
    checks++;
    if (n_out - n0 != want) begin
      failures++;
      $display("FAIL %s_beats_out: got %0d expected %0d", tag, n_out - n0, want);
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    idle(1);
  endtask

  task automatic test_match();
    int n0 = n_out;
    i_cfg_proto = IPPROT_UDP; i_cfg_port = '0; i_cfg_port[15:0] = 16'd5001;
    i_cfg_port_en = 4'b0001; i_cfg_bypass = 1'b0;
    make_pkt(IPPROT_UDP, 16'd5001, 4);
    send_pkt(0, 0, 99);
    drain();
    check_out("match", n0, 4);
    checks++;
    if (o_accept_cnt !== 32'd1) begin
      failures++;
      $display("FAIL match_accept: got %0d expected 1", o_accept_cnt);
    end
    check_counts("match");
  endtask

  task automatic test_back_to_back();
    int n0 = n_out;
    int unsigned a0 = m_acc, d0 = m_drop;
    make_pkt(IPPROT_UDP, 16'd5002, 4);
    send_pkt(0, 0, 99);
    make_pkt(IPPROT_UDP, 16'd5001, 4);
    send_pkt(0, 0, 99);
    drain();
    check_out("b2b", n0, 4);
    checks++;
    if (o_accept_cnt !== a0 + 1 || o_drop_cnt !== d0 + 1) begin
      failures++;
      $display("FAIL b2b_counts: got acc=%0d drop=%0d expected acc=%0d drop=%0d",
               o_accept_cnt, o_drop_cnt, a0 + 1, d0 + 1);
    end
  endtask

  task automatic test_proto_bypass();
    int n0 = n_out;
    int unsigned d0 = m_drop;
    make_pkt(8'h06, 16'd5001, 3);
    send_pkt(0, 0, 99);
    drain();
    check_out("proto_drop", n0, 0);
    checks++;
    if (o_drop_cnt !== d0 + 1) begin
      failures++;
      $display("FAIL proto_drop_cnt: got %0d expected %0d", o_drop_cnt, d0 + 1);
    end
    n0 = n_out;
    i_cfg_bypass = 1'b1;
    send_pkt(0, 0, 99);
    drain();
    i_cfg_bypass = 1'b0;
    check_out("bypass", n0, 3);
    check_counts("bypass");
  endtask

  task automatic test_runt();
    int n0 = n_out;
    int unsigned d0 = m_drop;
    make_pkt(IPPROT_UDP, 16'd0, 1);
    send_pkt(0, 0, 99);
    drain();
    check_out("runt", n0, 0);
    checks++;
    if (o_drop_cnt !== d0 + 1) begin
      failures++;
      $display("FAIL runt_drop_cnt: got %0d expected %0d", o_drop_cnt, d0 + 1);
    end
  endtask

  task automatic test_overflow();
    int n0 = n_out;
    int unsigned o0 = m_ovf, a0 = m_acc;
    rdy_mode = 0;
    make_pkt(IPPROT_UDP, 16'd5001, 10);
    send_pkt(0, 0, 99);
    make_pkt(IPPROT_UDP, 16'd5001, 10);
    send_pkt(0, 0, 99);
    idle(2);
    checks++;
    if (o_ovf_cnt !== o0 + 1 || o_accept_cnt !== a0 + 1) begin
      failures++;
      $display("FAIL ovf_counts: got ovf=%0d acc=%0d expected ovf=%0d acc=%0d",
               o_ovf_cnt, o_accept_cnt, o0 + 1, a0 + 1);
    end
    drain();
    check_out("ovf_release", n0, 10);
    n0 = n_out;
    make_pkt(IPPROT_UDP, 16'd5001, 20);
    send_pkt(0, 0, 99);
    drain();
    check_out("ovf_giant", n0, 0);
    checks++;
    if (o_ovf_cnt !== o0 + 2 || m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_giant: got ovf=%0d tvalid=%b expected ovf=%0d tvalid=0",
               o_ovf_cnt, m_axis_tvalid, o0 + 2);
    end
    check_counts("ovf");
  endtask

  task automatic test_random();
    logic [7:0]  proto;
    logic [15:0] dport;
    int          len;
    for (int p = 0; p < 60; p++) begin
      rdy_mode = 2;
      for (int k = 0; k < NP; k++) i_cfg_port[16*k +: 16] = 16'($urandom_range(5000, 5007));
      i_cfg_port_en = 4'($urandom());
      i_cfg_bypass  = ($urandom_range(0, 9) == 0);
      i_cfg_proto   = IPPROT_UDP;
      proto = ($urandom_range(0, 4) != 0) ? IPPROT_UDP : 8'($urandom_range(0, 255));
      dport = ($urandom_range(0, 2) != 0) ? i_cfg_port[16*$urandom_range(0, NP-1) +: 16]
                                          : 16'($urandom_range(5000, 5010));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 8);
      make_pkt(proto, dport, len);
      send_pkt(25, 1, 99);
    end
    i_cfg_bypass = 1'b0;
    drain();
    check_counts("random");
  endtask

  task automatic test_reset_mid();
    int n0;
    rdy_mode = 0;
    i_cfg_proto = IPPROT_UDP; i_cfg_port[15:0] = 16'd5001; i_cfg_port_en = 4'b0001;
    make_pkt(IPPROT_UDP, 16'd5001, 2);
    send_pkt(0, 0, 99);
    make_pkt(IPPROT_UDP, 16'd5001, 4);
    send_pkt(0, 0, 2);
    do_reset(1);
    idle(1);
    n0 = n_out;
    make_pkt(IPPROT_UDP, 16'd5001, 3);
    send_pkt(0, 0, 99);
    drain();
    check_out("after_reset", n0, 3);
    check_counts("after_reset");
  endtask

  initial begin
    axis_reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tuser = '0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    i_cfg_proto = IPPROT_UDP; i_cfg_port = '0; i_cfg_port_en = '0; i_cfg_bypass = 1'b0;
    @(negedge axis_aclk);
    test_reset();
    test_match();
    test_back_to_back();
    test_proto_bypass();
    test_runt();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
